// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S/TDM receive controller: state encoding,
// configuration field widths and the configuration sanity check.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int TDM_W          = 5;
    localparam int WW_W           = 6;
    localparam int MAX_WORD_WIDTH = 32;

    // A geometry the PHY can honour: at least one slot, 1..32 bclks per slot,
    // and no more valid bits than the slot holds.
    function automatic logic cfg_ok(
        input logic [TDM_W-1:0] tdm_num,
        input logic [WW_W-1:0]  word_width,
        input logic [WW_W-1:0]  valid_word_width
    );
        return (tdm_num != '0)
            && (word_width != '0)
            && (word_width <= WW_W'(MAX_WORD_WIDTH))
            && (valid_word_width <= word_width);
    endfunction

endpackage

// File: rtl/i2s_rx_ctrl_if.sv
// Register-block / PHY side bundle of the receive controller.
// Carries o_byte_err_count only when I2S_RX_CTRL_BYTE_CHECK_EN is defined.
interface i2s_rx_ctrl_if;
    import i2s_pkg::*;

    logic                  cfg_start;
    logic [TDM_W-1:0]      cfg_tdm_num;
    logic [WW_W-1:0]       cfg_word_width;
    logic [WW_W-1:0]       cfg_valid_word_width;
    logic                  cfg_lrck_polarity;
    logic                  cfg_lrck_alignment;
    logic                  lrck;
    logic                  phy_tvalid;
    logic                  phy_tlast;

    logic [TDM_W-1:0]      phy_tdm_num;
    logic [WW_W-1:0]       phy_word_width;
    logic [WW_W-1:0]       phy_valid_word_width;
    logic                  phy_lrck_polarity;
    logic                  phy_lrck_alignment;
    logic                  phy_enable;
    logic [1:0]            o_state;
    logic                  o_locked;
    logic [31:0]           o_frame_num;
    logic [15:0]           o_err_count;
    logic                  o_err_pulse;
    logic                  o_cfg_err;
`ifdef I2S_RX_CTRL_BYTE_CHECK_EN
    logic [15:0]           o_byte_err_count;
`endif

    modport master (
`ifdef I2S_RX_CTRL_BYTE_CHECK_EN
        input  o_byte_err_count,
`endif
        output cfg_start, cfg_tdm_num, cfg_word_width, cfg_valid_word_width,
               cfg_lrck_polarity, cfg_lrck_alignment, lrck, phy_tvalid, phy_tlast,
        input  phy_tdm_num, phy_word_width, phy_valid_word_width, phy_lrck_polarity,
               phy_lrck_alignment, phy_enable, o_state, o_locked, o_frame_num,
               o_err_count, o_err_pulse, o_cfg_err
    );

    modport slave (
`ifdef I2S_RX_CTRL_BYTE_CHECK_EN
        output o_byte_err_count,
`endif
        input  cfg_start, cfg_tdm_num, cfg_word_width, cfg_valid_word_width,
               cfg_lrck_polarity, cfg_lrck_alignment, lrck, phy_tvalid, phy_tlast,
        output phy_tdm_num, phy_word_width, phy_valid_word_width, phy_lrck_polarity,
               phy_lrck_alignment, phy_enable, o_state, o_locked, o_frame_num,
               o_err_count, o_err_pulse, o_cfg_err
    );

endinterface

// File: rtl/i2s_period_meter.sv
// lrck edge detector and frame-period counter; flags each period as good
// (counter == period at a start edge) or bad (wrong length, or overrun).
module i2s_period_meter #(
    parameter int CNT_W = 11
) (
    input  logic             bclk,
    input  logic             rst,
    input  logic             lrck,
    input  logic             polarity,
    input  logic [CNT_W-1:0] period,
    output logic             start_edge,
    output logic             good,
    output logic             bad
);

    logic             q1_reg;
    logic             q2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             late_reg;
    logic             overrun;
    logic [CNT_W:0]   period_plus1;

    assign period_plus1 = {1'b0, period} + (CNT_W+1)'(1);

    always_comb begin
        start_edge = polarity ? (q2_reg & ~q1_reg) : (q1_reg ^ q2_reg);
        // late_reg keeps an overrun from being reported twice if the counter
        // saturates right at period+1
        overrun    = ~start_edge & ~late_reg & ({1'b0, cnt_reg} == period_plus1);
        good       = start_edge & (cnt_reg == period);
        bad        = (start_edge & (cnt_reg != period)) | overrun;
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            q1_reg   <= 1'b0;
            q2_reg   <= 1'b0;
            cnt_reg  <= '0;
            late_reg <= 1'b0;
        end else begin
            q1_reg <= lrck;
            q2_reg <= q1_reg;
            if (start_edge) begin
                cnt_reg  <= CNT_W'(1);
                late_reg <= 1'b0;
            end else begin
                if (cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                if (overrun) begin
                    late_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S/TDM receive sequencing controller: shadows the PHY configuration, locks
// on lrck, gates phy_enable and keeps counters. Optional I2S_RX_CTRL_BYTE_CHECK_EN.
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int LOCK_FRAMES = 4,
    parameter int MISS_LIMIT  = 2,
    parameter int CNT_W       = 11
) (
    input logic          bclk,
    input logic          rst,
    i2s_rx_ctrl_if.slave bus
);

    state_t           state_reg;
    logic [TDM_W-1:0] tdm_reg;
    logic [WW_W-1:0]  ww_reg;
    logic [WW_W-1:0]  vww_reg;
    logic             pol_reg;
    logic             align_reg;
    logic [CNT_W-1:0] period_reg;
    logic [3:0]       run_cnt_reg;
    logic             armed_reg;
    logic [3:0]       miss_cnt_reg;
    logic [CNT_W:0]   drain_cnt_reg;
    logic             phy_enable_reg;
    logic             locked_reg;
    logic [31:0]      frame_reg;
    logic [15:0]      err_cnt_reg;
    logic             err_pulse_reg;
    logic             cfg_err_reg;

    logic             start_edge;
    logic             good;
    logic             bad;
    logic [CNT_W-1:0] period_calc;

    assign period_calc = CNT_W'(bus.cfg_tdm_num) * CNT_W'(bus.cfg_word_width);

    i2s_period_meter #(.CNT_W(CNT_W)) u_meter (
        .bclk       (bclk),
        .rst        (rst),
        .lrck       (bus.lrck),
        .polarity   (pol_reg),
        .period     (period_reg),
        .start_edge (start_edge),
        .good       (good),
        .bad        (bad)
    );

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tdm_reg        <= '0;
            ww_reg         <= '0;
            vww_reg        <= '0;
            pol_reg        <= 1'b0;
            align_reg      <= 1'b0;
            period_reg     <= '0;
            run_cnt_reg    <= '0;
            armed_reg      <= 1'b0;
            miss_cnt_reg   <= '0;
            drain_cnt_reg  <= '0;
            phy_enable_reg <= 1'b0;
            locked_reg     <= 1'b0;
            frame_reg      <= '0;
            err_cnt_reg    <= '0;
            err_pulse_reg  <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            if (bus.phy_tlast && (state_reg == ST_RUN || state_reg == ST_DRAIN)) begin
                frame_reg <= frame_reg + 32'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    tdm_reg        <= bus.cfg_tdm_num;
                    ww_reg         <= bus.cfg_word_width;
                    vww_reg        <= bus.cfg_valid_word_width;
                    pol_reg        <= bus.cfg_lrck_polarity;
                    align_reg      <= bus.cfg_lrck_alignment;
                    phy_enable_reg <= 1'b0;
                    locked_reg     <= 1'b0;
                    if (!bus.cfg_start) begin
                        cfg_err_reg <= 1'b0;
                    end else if (cfg_ok(bus.cfg_tdm_num, bus.cfg_word_width,
                                        bus.cfg_valid_word_width)) begin
                        cfg_err_reg <= 1'b0;
                        period_reg  <= period_calc;
                        run_cnt_reg <= '0;
                        armed_reg   <= 1'b0;
                        state_reg   <= ST_SEARCH;
                    end else begin
                        cfg_err_reg <= 1'b1;
                    end
                end

                ST_SEARCH: begin
                    if (!bus.cfg_start) begin
                        state_reg <= ST_IDLE;
                    end else if (start_edge && !armed_reg) begin
                        // the counter was mid-period on entry, so this edge only aligns it
                        armed_reg <= 1'b1;
                    end else if (armed_reg && good) begin
                        if (run_cnt_reg + 4'd1 >= 4'(LOCK_FRAMES)) begin
                            state_reg      <= ST_RUN;
                            phy_enable_reg <= 1'b1;
                            locked_reg     <= 1'b1;
                            miss_cnt_reg   <= '0;
                            run_cnt_reg    <= '0;
                        end else begin
                            run_cnt_reg <= run_cnt_reg + 4'd1;
                        end
                    end else if (armed_reg && bad) begin
                        run_cnt_reg <= '0;
                    end
                end

                ST_RUN: begin
                    if (bad) begin
                        err_pulse_reg <= 1'b1;
                        if (err_cnt_reg != '1) begin
                            err_cnt_reg <= err_cnt_reg + 16'd1;
                        end
                    end
                    if (!bus.cfg_start) begin
                        state_reg      <= ST_DRAIN;
                        phy_enable_reg <= 1'b0;
                        locked_reg     <= 1'b0;
                        drain_cnt_reg  <= '0;
                    end else if (bad && (miss_cnt_reg + 4'd1 >= 4'(MISS_LIMIT))) begin
                        state_reg      <= ST_SEARCH;
                        phy_enable_reg <= 1'b0;
                        locked_reg     <= 1'b0;
                        armed_reg      <= 1'b0;
                        run_cnt_reg    <= '0;
                        miss_cnt_reg   <= '0;
                    end else if (bad) begin
                        miss_cnt_reg <= miss_cnt_reg + 4'd1;
                    end else if (good) begin
                        miss_cnt_reg <= '0;
                    end
                end

                ST_DRAIN: begin
                    // bounded wait so a silent PHY cannot hold us here forever
                    if (bus.phy_tlast || (drain_cnt_reg == {1'b0, period_reg} + (CNT_W+1)'(1))) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + (CNT_W+1)'(1);
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef I2S_RX_CTRL_BYTE_CHECK_EN
    logic [15:0] beat_cnt_reg;
    logic [15:0] byte_err_reg;
    logic        byte_armed_reg;
    logic [15:0] beats_exp;
    logic [15:0] beats_now;

    assign beats_exp = 16'(tdm_reg) * 16'(vww_reg >> 3);
    assign beats_now = beat_cnt_reg + 16'(bus.phy_tvalid);

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            beat_cnt_reg   <= '0;
            byte_err_reg   <= '0;
            byte_armed_reg <= 1'b0;
        end else if (state_reg != ST_RUN) begin
            beat_cnt_reg   <= '0;
            byte_armed_reg <= 1'b0;
        end else if (bus.phy_tlast) begin
            // the first frame in RUN may have started before we were counting
            beat_cnt_reg   <= '0;
            byte_armed_reg <= 1'b1;
            if (byte_armed_reg && (beats_now != beats_exp) && (byte_err_reg != '1)) begin
                byte_err_reg <= byte_err_reg + 16'd1;
            end
        end else if (bus.phy_tvalid) begin
            beat_cnt_reg <= beat_cnt_reg + 16'd1;
        end
    end

    assign bus.o_byte_err_count = byte_err_reg;
`endif

    assign bus.phy_tdm_num          = tdm_reg;
    assign bus.phy_word_width       = ww_reg;
    assign bus.phy_valid_word_width = vww_reg;
    assign bus.phy_lrck_polarity    = pol_reg;
    assign bus.phy_lrck_alignment   = align_reg;
    assign bus.phy_enable           = phy_enable_reg;
    assign bus.o_state              = state_reg;
    assign bus.o_locked             = locked_reg;
    assign bus.o_frame_num          = frame_reg;
    assign bus.o_err_count          = err_cnt_reg;
    assign bus.o_err_pulse          = err_pulse_reg;
    assign bus.o_cfg_err            = cfg_err_reg;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl: lock, error/fallback, config reject, drain,
// shadow stability, async reset and falling-edge-only framing.
module tb_i2s_rx_ctrl;

    logic bclk = 1'b0;
    logic rst;

    i2s_rx_ctrl_if bus ();

    i2s_rx_ctrl #(
        .LOCK_FRAMES (4),
        .MISS_LIMIT  (2),
        .CNT_W       (11)
    ) dut (
        .bclk (bclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 bclk = ~bclk;

    int errors = 0;
    int checks = 0;

    // lrck source: each half lasts half_len bclks; stretch_req asks for
    // that many upcoming halves to be one bclk longer
    int half_len    = 64;
    int stretch_req = 0;
    int stretch_done = 0;
    int lr_n;

    initial begin
        bus.lrck = 1'b0;
        forever begin
            lr_n = half_len;
            if (stretch_done < stretch_req) begin
                lr_n = lr_n + 1;
                stretch_done = stretch_done + 1;
            end
            repeat (lr_n) @(negedge bclk);
            bus.lrck = ~bus.lrck;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge bclk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [1:0] st, input int budget, output int cyc);
        cyc = 0;
        while (bus.o_state !== st && cyc < budget) begin
            step(1);
            cyc++;
        end
        check(tag, {30'd0, bus.o_state}, {30'd0, st});
    endtask

    task automatic frame_beats(input int n);
        bus.phy_tvalid = 1'b1;
        step(n);
        bus.phy_tlast = 1'b1;
        step(1);
        bus.phy_tvalid = 1'b0;
        bus.phy_tlast  = 1'b0;
    endtask

    int cyc;
    int n;

    initial begin
        rst = 1'b1;
        bus.cfg_start            = 1'b0;
        bus.cfg_tdm_num          = 5'd0;
        bus.cfg_word_width       = 6'd32;
        bus.cfg_valid_word_width = 6'd24;
        bus.cfg_lrck_polarity    = 1'b0;
        bus.cfg_lrck_alignment   = 1'b1;
        bus.phy_tvalid           = 1'b0;
        bus.phy_tlast            = 1'b0;
        step(3);
        check("rst_state", {30'd0, bus.o_state}, 32'd0);
        check("rst_enable", {31'd0, bus.phy_enable}, 32'd0);
        check("rst_ww", {26'd0, bus.phy_word_width}, 32'd0);
        check("rst_frames", bus.o_frame_num, 32'd0);
        rst = 1'b0;

        // rejected geometry: zero slots
        bus.cfg_start = 1'b1;
        step(3);
        check("cfg_err_state", {30'd0, bus.o_state}, 32'd0);
        check("cfg_err_set", {31'd0, bus.o_cfg_err}, 32'd1);
        check("shadow_ww_idle", {26'd0, bus.phy_word_width}, 32'd32);
        check("shadow_align", {31'd0, bus.phy_lrck_alignment}, 32'd1);
        bus.cfg_start = 1'b0;
        step(2);
        check("cfg_err_clear", {31'd0, bus.o_cfg_err}, 32'd0);

        // 2 slots x 32 bclks = 64-bclk period, lrck half = 64 with both edges framing
        bus.cfg_tdm_num = 5'd2;
        bus.cfg_start   = 1'b1;
        step(1);
        check("search_state", {30'd0, bus.o_state}, 32'd1);
        check("search_enable", {31'd0, bus.phy_enable}, 32'd0);
        wait_state("lock_run", 2'd2, 1000, cyc);
        check("lock_time_ok", {31'd0, (cyc >= 250 && cyc <= 330)}, 32'd1);
        check("run_enable", {31'd0, bus.phy_enable}, 32'd1);
        check("run_locked", {31'd0, bus.o_locked}, 32'd1);
        check("run_err0", {16'd0, bus.o_err_count}, 32'd0);

        // frame counting; expected beats per frame = 2 * (24 >> 3) = 6
        bus.phy_tlast = 1'b1;
        step(1);
        bus.phy_tlast = 1'b0;
        check("frames_1", bus.o_frame_num, 32'd1);
        frame_beats(4);
        check("frames_2", bus.o_frame_num, 32'd2);
`ifdef I2S_RX_CTRL_BYTE_CHECK_EN
        check("byte_err_short", {16'd0, bus.o_byte_err_count}, 32'd1);
`endif
        frame_beats(5);
        check("frames_3", bus.o_frame_num, 32'd3);
`ifdef I2S_RX_CTRL_BYTE_CHECK_EN
        check("byte_err_exact", {16'd0, bus.o_byte_err_count}, 32'd1);
`endif

        // one long half: single error, lock kept
        stretch_req = stretch_req + 1;
        n = 0;
        while (bus.o_err_pulse !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        check("err_pulse_seen", {31'd0, bus.o_err_pulse}, 32'd1);
        check("err_count_1", {16'd0, bus.o_err_count}, 32'd1);
        check("still_run", {30'd0, bus.o_state}, 32'd2);
        step(1);
        check("err_pulse_1cyc", {31'd0, bus.o_err_pulse}, 32'd0);
        step(150);
        check("err_count_hold", {16'd0, bus.o_err_count}, 32'd1);
        check("run_after_1bad", {30'd0, bus.o_state}, 32'd2);

        // config change outside IDLE must not reach the PHY
        bus.cfg_word_width = 6'd16;
        step(3);
        check("shadow_ww_run", {26'd0, bus.phy_word_width}, 32'd32);

        // two long halves in a row: fall back to SEARCH
        stretch_req = stretch_req + 2;
        wait_state("fallback_search", 2'd1, 400, cyc);
        check("fallback_enable", {31'd0, bus.phy_enable}, 32'd0);
        check("fallback_locked", {31'd0, bus.o_locked}, 32'd0);
        check("err_count_3", {16'd0, bus.o_err_count}, 32'd3);
        check("shadow_ww_srch", {26'd0, bus.phy_word_width}, 32'd32);
        bus.cfg_word_width = 6'd32;
        wait_state("relock_run", 2'd2, 1000, cyc);

        // stop with a frame end arriving during drain
        bus.cfg_start = 1'b0;
        step(1);
        check("drain_state", {30'd0, bus.o_state}, 32'd3);
        check("drain_enable", {31'd0, bus.phy_enable}, 32'd0);
        step(10);
        bus.phy_tlast = 1'b1;
        step(1);
        bus.phy_tlast = 1'b0;
        check("drain_tlast_idle", {30'd0, bus.o_state}, 32'd0);
        check("frames_4", bus.o_frame_num, 32'd4);

        // stop with no frame end: drain lasts P+2 = 66 bclks, restart ignored meanwhile
        bus.cfg_start = 1'b1;
        wait_state("run_again", 2'd2, 1000, cyc);
        bus.cfg_start = 1'b0;
        step(1);
        n = 0;
        while (bus.o_state === 2'd3 && n < 200) begin
            n++;
            if (n == 5) bus.cfg_start = 1'b1;
            step(1);
        end
        check("drain_timeout", n, 32'd66);
        check("drain_to_idle", {30'd0, bus.o_state}, 32'd0);
        step(1);
        check("idle_restart", {30'd0, bus.o_state}, 32'd1);
        check("frames_kept", bus.o_frame_num, 32'd4);

        // asynchronous reset in the middle of RUN
        wait_state("run_pre_rst", 2'd2, 1000, cyc);
        #3;
        rst = 1'b1;
        #1;
        check("arst_state", {30'd0, bus.o_state}, 32'd0);
        check("arst_enable", {31'd0, bus.phy_enable}, 32'd0);
        check("arst_errs", {16'd0, bus.o_err_count}, 32'd0);
        check("arst_frames", bus.o_frame_num, 32'd0);
        check("arst_locked", {31'd0, bus.o_locked}, 32'd0);
        bus.cfg_start = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        check("post_rst_idle", {30'd0, bus.o_state}, 32'd0);

        // falling edge only: half = 32, full lrck cycle = 64 = P
        half_len = 32;
        bus.cfg_lrck_polarity = 1'b1;
        bus.cfg_start = 1'b1;
        wait_state("pol1_lock", 2'd2, 1000, cyc);
        check("pol1_shadow", {31'd0, bus.phy_lrck_polarity}, 32'd1);
        check("pol1_errs", {16'd0, bus.o_err_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
